// File: rtl/roulette_reader_if.sv
// Signal bundle between the roulette driver/button side and roulette_reader.
// The reader consumes seg_in/key_n and produces the decoded and captured results.
interface roulette_reader_if;
  logic [6:0] seg_in;
  logic       key_n;
  logic [2:0] pos;
  logic       pos_valid;
  logic       hold;
  logic       hit;
  logic       err;
  logic [7:0] hit_cnt;

  modport master (
    output seg_in, key_n,
    input  pos, pos_valid, hold, hit, err, hit_cnt
  );

  modport slave (
    input  seg_in, key_n,
    output pos, pos_valid, hold, hit, err, hit_cnt
  );
endinterface

// File: rtl/roulette_reader.sv
// Reads a spinning one-hot 7-segment roulette, freezes it on a debounced button
// press, and reports whether the captured segment is the winning one.
module roulette_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TARGET          = 0
) (
  input  logic              clk,
  input  logic              rst,
  roulette_reader_if.slave  bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RUN, HOLD} state_e;

  logic             key_s1_q, key_s2_q;
  logic             key_db_q, key_db_prev_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic             press;

  logic [5:0]       lit;
  logic [2:0]       n_lit;
  logic [2:0]       live_pos_d, live_pos_q;
  logic             live_valid_d, live_valid_q;

  state_e           state_q;
  logic [2:0]       pos_q;
  logic             pos_valid_q, hold_q, hit_q, err_q;
  logic [7:0]       hit_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the two synchronizer stages really are two stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= bus.key_n;
      key_s2_q <= key_s1_q;
    end
  end

  // Level only flips after an unbroken run of samples that disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      db_cnt_q      <= '0;
    end else begin
      key_db_prev_q <= key_db_q;
      if (key_s2_q != key_db_q) begin
        if (db_cnt_q == CNT_LAST) begin
          key_db_q <= key_s2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign press = key_db_prev_q & ~key_db_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    lit          = ~bus.seg_in[5:0];
    n_lit        = '0;
    live_pos_d   = '0;
    for (int k = 0; k < 6; k++) begin
      if (lit[k]) begin
        live_pos_d = 3'(k);
        n_lit      = n_lit + 3'd1;
      end
    end
    live_valid_d = (n_lit == 3'd1) && bus.seg_in[6];
    if (!live_valid_d) live_pos_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_pos_q   <= '0;
      live_valid_q <= 1'b0;
    end else begin
      live_pos_q   <= live_pos_d;
      live_valid_q <= live_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      hold_q      <= 1'b0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      hit_cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (press) begin
            state_q     <= HOLD;
            hold_q      <= 1'b1;
            pos_q       <= live_pos_q;
            pos_valid_q <= live_valid_q;
            err_q       <= ~live_valid_q;
            hit_q       <= live_valid_q && (live_pos_q == 3'(TARGET));
            if (live_valid_q && (live_pos_q == 3'(TARGET)) && (hit_cnt_q != 8'hFF))
              hit_cnt_q <= hit_cnt_q + 8'd1;
          end else begin
            pos_q       <= live_pos_d;
            pos_valid_q <= live_valid_d;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        HOLD: begin
          if (press) begin
            state_q <= RUN;
            hold_q  <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pos       = pos_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.hold      = hold_q;
  assign bus.hit       = hit_q;
  assign bus.err       = err_q;
  assign bus.hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_roulette_reader.sv
// Bench for roulette_reader: decode table, hand-written button sequences,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_roulette_reader;

  localparam int DEB    = 4;
  localparam int TARGET = 0;

  logic clk = 1'b0;
  logic rst;
  roulette_reader_if bus();

  roulette_reader #(.DEBOUNCE_CYCLES(DEB), .TARGET(TARGET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_s1, m_s2, m_db, m_db_prev;
  bit       m_win[$];
  bit [2:0] m_lpos;
  bit       m_lvalid;
  bit       m_hold, m_valid, m_hit, m_err;
  bit [2:0] m_pos;
  int       m_cnt;

  function automatic void decode(input logic [6:0] seg, output bit [2:0] p, output bit v);
    int lit;
    lit = int'(~seg[5:0]) & 'h3F;
    v   = ($countones(lit) == 1) && seg[6];
    p   = v ? 3'($clog2(lit)) : 3'd0;
  endfunction

  task automatic model_step();
    bit       press, all_diff, dval;
    bit [2:0] dpos;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_db = 1; m_db_prev = 1;
      m_win.delete();
      m_lpos = 0; m_lvalid = 0;
      m_hold = 0; m_valid = 0; m_hit = 0; m_err = 0; m_pos = 0; m_cnt = 0;
      return;
    end
    press = m_db_prev && !m_db;
    decode(bus.seg_in, dpos, dval);
    if (!m_hold) begin
      if (press) begin
        m_pos = m_lpos; m_valid = m_lvalid; m_err = !m_lvalid;
        m_hit = m_lvalid && (m_lpos == TARGET);
        if (m_hit) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        m_hold = 1;
      end else begin
        m_pos = dpos; m_valid = dval; m_hit = 0; m_err = 0;
      end
    end else if (press) begin
      m_hold = 0; m_hit = 0; m_err = 0;
    end
    m_db_prev = m_db;
    // debounced level flips once the last DEB synchronized samples all disagree with it
    m_win.push_back(m_s2);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    if (m_win.size() == DEB) begin
      all_diff = 1;
      foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db = !m_db;
        m_win.delete();
      end
    end
    m_s2 = m_s1; m_s1 = bus.key_n;
    m_lpos = dpos; m_lvalid = dval;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key();
    bus.key_n = 1'b0; tick(8);
    bus.key_n = 1'b1; tick(8);
  endtask

  typedef struct {
    logic [6:0] seg;
    logic [2:0] exp_pos;
    logic       exp_valid;
  } dec_vec_t;

  dec_vec_t vecs[10];

  initial begin
    vecs[0] = '{7'b1111110, 3'd0, 1'b1};
    vecs[1] = '{7'b1111101, 3'd1, 1'b1};
    vecs[2] = '{7'b1111011, 3'd2, 1'b1};
    vecs[3] = '{7'b1110111, 3'd3, 1'b1};
    vecs[4] = '{7'b1101111, 3'd4, 1'b1};
    vecs[5] = '{7'b1011111, 3'd5, 1'b1};
    vecs[6] = '{7'b0111110, 3'd0, 1'b0};
    vecs[7] = '{7'b1111100, 3'd0, 1'b0};
    vecs[8] = '{7'b1111111, 3'd0, 1'b0};
    vecs[9] = '{7'b0111111, 3'd0, 1'b0};

    rst = 1'b1; bus.key_n = 1'b1; bus.seg_in = 7'b1111111;
    tick(2);
    check("reset_outputs", {bus.pos, bus.pos_valid, bus.hold, bus.hit, bus.err, bus.hit_cnt}, '0);
    rst = 1'b0;
    tick(2);

    // decode table, one cycle after each change
    foreach (vecs[i]) begin
      bus.seg_in = vecs[i].seg;
      tick(1);
      check($sformatf("decode_pos[%0d]", i), bus.pos, vecs[i].exp_pos);
      check($sformatf("decode_valid[%0d]", i), bus.pos_valid, vecs[i].exp_valid);
      check($sformatf("decode_hold[%0d]", i), bus.hold, 1'b0);
    end

    // hit capture, then seg_in changes while held
    bus.seg_in = 7'b1111110; tick(2);
    bus.key_n = 1'b0; tick(10);
    check("hit_hold", bus.hold, 1'b1);
    check("hit_hit", bus.hit, 1'b1);
    check("hit_cnt_1", bus.hit_cnt, 8'd1);
    bus.seg_in = 7'b1111011; tick(3);
    check("hold_frozen_pos", bus.pos, 3'd0);
    check("hold_frozen_valid", bus.pos_valid, 1'b1);
    bus.key_n = 1'b1; tick(8);
    press_key();
    check("release_run", {bus.hold, bus.hit, bus.err}, 3'b000);
    tick(2);
    check("resume_track", bus.pos, 3'd2);

    // bounce rejection, then a 6-cycle press that must count once
    bus.key_n = 1'b0; tick(3);
    bus.key_n = 1'b1; tick(1);
    bus.key_n = 1'b0; tick(3);
    bus.key_n = 1'b1; tick(12);
    check("bounce_no_event", bus.hold, 1'b0);
    bus.key_n = 1'b0; tick(6);
    bus.key_n = 1'b1; tick(12);
    check("six_cycle_event", bus.hold, 1'b1);
    check("six_cycle_nohit", bus.hit, 1'b0);
    press_key();
    check("six_cycle_back", bus.hold, 1'b0);

    // illegal pattern at press
    bus.seg_in = 7'b1111100; tick(2);
    press_key();
    check("illegal_err", {bus.hold, bus.err, bus.hit, bus.pos_valid, bus.pos}, {1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
    check("illegal_cnt", bus.hit_cnt, 8'd1);
    press_key();
    check("illegal_clear", {bus.hold, bus.err}, 2'b00);

    // key held low across reset: one event after sync + debounce delay
    bus.key_n = 1'b0; rst = 1'b1; tick(1);
    rst = 1'b0;
    tick(6);
    check("held_before", bus.hold, 1'b0);
    tick(1);
    check("held_event", bus.hold, 1'b1);
    tick(10);
    check("held_one_event", bus.hold, 1'b1);
    bus.key_n = 1'b1; tick(8);
    press_key();

    // randomized traffic against the model
    begin
      int run_left = 0;
      for (int c = 0; c < 4000; c++) begin
        if (run_left == 0) begin
          bus.key_n = ~bus.key_n;
          run_left  = $urandom_range(1, 9);
        end
        run_left--;
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 9) < 7) bus.seg_in = ~(7'd1 << $urandom_range(0, 5));
          else                          bus.seg_in = 7'($urandom);
        end
        rst = ($urandom_range(0, 299) == 0);
        tick(1);
        check("random_vs_model",
              {bus.pos, bus.pos_valid, bus.hold, bus.hit, bus.err, bus.hit_cnt},
              {m_pos, m_valid, m_hold, m_hit, m_err, 8'(m_cnt)});
      end
      rst = 1'b0;
    end

    // saturation: 256 hit captures, then reset while held
    bus.key_n = 1'b1; rst = 1'b1; tick(1);
    rst = 1'b0; bus.seg_in = 7'b1111110; tick(8);
    for (int k = 1; k <= 256; k++) begin
      press_key();
      if (k == 255) check("sat_255", bus.hit_cnt, 8'd255);
      if (k < 256) press_key();
    end
    check("sat_no_wrap", bus.hit_cnt, 8'd255);
    check("sat_in_hold", bus.hold, 1'b1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("reset_mid_hold", {bus.hold, bus.hit, bus.hit_cnt}, 10'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/roulette_reader.md
ROULETTE_READER -- requirements
Module: roulette_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a new key level (10 ms at 50 MHz).
REQ-002 Parameter TARGET, default 0, winning segment position, range 0..5.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 seg_in  input  7  active-low 7-segment bus from the roulette driver; bit k = segment k (a..g), bit 6 = g.
REQ-007 key_n  input  1  asynchronous push button, active-low (0 = pressed).
REQ-008 pos  output  3  decoded lit-segment position 0..5.
REQ-009 pos_valid  output  1  pos holds a legal decode.
REQ-010 hold  output  1  FSM is in HOLD.
REQ-011 hit  output  1  captured position equals TARGET.
REQ-012 err  output  1  captured pattern was illegal.
REQ-013 hit_cnt  output  8  number of hits since reset, saturating.

Function
REQ-014 key_n SHALL pass a 2-flop synchronizer before any other logic.
REQ-015 Debouncer: the synchronized key SHALL update the debounced level only after DEBOUNCE_CYCLES consecutive cycles that differ from it; any earlier toggle SHALL restart the count. The counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-016 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition. Release SHALL generate no event.
REQ-017 Decode: with lit = ~seg_in[5:0], the pattern is legal iff exactly one lit bit is set and seg_in[6] = 1. The live position is the index of that bit.
REQ-018 The live decode SHALL be registered, giving 1 cycle of latency from seg_in to the live position and live-valid.
REQ-019 The FSM SHALL have two states, RUN and HOLD. Reset enters RUN.
REQ-020 In RUN, pos and pos_valid SHALL track the registered live decode. Hit and err SHALL be 0.
REQ-021 RUN + press: capture the registered live decode into pos/pos_valid and enter HOLD. In the same cycle set err = ~valid, and set hit = valid and (pos == TARGET).
REQ-022 On each captured hit, hit_cnt SHALL increment by 1, saturating at 255 (no wrap).
REQ-023 HOLD: pos, pos_valid, hit and err SHALL stay frozen regardless of seg_in.
REQ-024 HOLD + press: clear hit and err and return to RUN. pos resumes tracking on the next cycle.
REQ-025 Latency: a press pulse in cycle N SHALL make hold, hit, err and hit_cnt visible in cycle N+1.
REQ-026 An illegal pattern (zero lit, more than one lit, or g lit) captured at press SHALL give err = 1, hit = 0, pos_valid = 0, pos = 0, and no hit_cnt change.
REQ-027 A held key SHALL generate exactly one event. A new event requires a debounced release followed by a new press.

Reset
REQ-028 rst SHALL force the following in the next clock: synchronizer and debounced level = 1 (released), debounce count = 0, FSM = RUN, and pos, pos_valid, hit, err, hold, hit_cnt = 0.
REQ-029 rst SHALL take priority over a press event in the same cycle. A reset during HOLD SHALL discard the capture.
REQ-030 After reset, a key already held low SHALL produce one event after synchronizer delay plus DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES = 4, TARGET = 0)
REQ-031 Track: seg_in = 7'b1111110, then 7'b1111101 -> pos = 0, then pos = 1, one cycle after each change, with pos_valid = 1 and hold = 0.
REQ-032 Hit: seg_in = 7'b1111110, key_n low for 10 cycles -> hold = 1, hit = 1, hit_cnt = 1. Changing seg_in during HOLD leaves pos = 0.
REQ-033 Bounce: key_n low 3 cycles, high 1 cycle, low 3 cycles, then high -> no event and hold stays 0. Low for 6 or more cycles -> exactly one event.
REQ-034 Illegal: seg_in = 7'b1111100 at press -> err = 1, hit = 0, pos_valid = 0, hit_cnt unchanged. A second press returns to RUN with err = 0.
REQ-035 Saturation: 256 hit captures -> hit_cnt = 255. Reset mid-HOLD -> hold = 0 and hit_cnt = 0 in the next cycle.
